// File: rtl/mips_defs.sv
// Shared MIPS definitions for the HI/LO multiply/divide unit.
// Holds the R-type funct codes handled by the unit and the iteration FSM state type.
package mips_defs;

  localparam logic [5:0] FunctMfhi  = 6'h10;
  localparam logic [5:0] FunctMthi  = 6'h11;
  localparam logic [5:0] FunctMflo  = 6'h12;
  localparam logic [5:0] FunctMtlo  = 6'h13;
  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctMultu = 6'h19;
  localparam logic [5:0] FunctDiv   = 6'h1A;
  localparam logic [5:0] FunctDivu  = 6'h1B;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } md_state_e;

endpackage

// File: rtl/md_iter_step.sv
// Single radix-2 iteration for the multiply/divide accumulator pair.
// Ports:
//   is_div           1: restoring shift-subtract step, 0: shift-add step
//   acc_hi, acc_lo   current accumulator (mult: partial product / multiplier,
//                    div: partial remainder / dividend-becoming-quotient)
//   operand          multiplicand magnitude (mult) or divisor magnitude (div)
//   next_hi, next_lo accumulator after one iteration
module md_iter_step #(
  parameter int unsigned Width = 32
) (
  input  logic             is_div,
  input  logic [Width-1:0] acc_hi,
  input  logic [Width-1:0] acc_lo,
  input  logic [Width-1:0] operand,
  output logic [Width-1:0] next_hi,
  output logic [Width-1:0] next_lo
);

  logic [Width:0] sum;
  logic [Width:0] shifted;
  logic [Width:0] diff;

  // Add the multiplicand when the current multiplier LSB is set; carry kept in bit Width.
  assign sum     = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? operand : '0)};
  // Bring the next dividend bit into the partial remainder.
  assign shifted = {acc_hi, acc_lo[Width-1]};
  // Borrow shows up in the top bit because shifted < 2 * divisor.
  assign diff    = shifted - {1'b0, operand};

  always_comb begin
    next_hi = acc_hi;
    next_lo = acc_lo;
    if (is_div) begin
      if (!diff[Width]) begin
        next_hi = diff[Width-1:0];
        next_lo = {acc_lo[Width-2:0], 1'b1};
      end else begin
        next_hi = shifted[Width-1:0];
        next_lo = {acc_lo[Width-2:0], 1'b0};
      end
    end else begin
      next_hi = sum[Width:1];
      next_lo = {sum[0], acc_lo[Width-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the R-type MIPS datapath.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   start, funct          request qualifier and R-type funct field
//   rs_data, rt_data      register-file read data (dividend/multiplicand, divisor/multiplier)
//   busy                  operation in flight, control must stall
//   done                  one-cycle pulse when a mult/div updates HI/LO
//   div_by_zero           sticky flag, cleared by the next accepted op
//   hi, lo                architectural HI/LO registers
//   mf_data               hi for mfhi, otherwise lo (combinational)
module mult_div_unit
  import mips_defs::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int unsigned CntW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;   // negate product / quotient
  logic             neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             is_mul_op, is_div_op, signed_op;
  logic [WIDTH-1:0] abs_rs, abs_rt;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign is_mul_op = (funct == FunctMult) || (funct == FunctMultu);
  assign is_div_op = (funct == FunctDiv) || (funct == FunctDivu);
  assign signed_op = (funct == FunctMult) || (funct == FunctDiv);

  // Unsigned magnitudes: abs(0x80..0) is 0x80..0 as an unsigned value, which the
  // iterative datapath handles without an extra bit.
  assign abs_rs = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign abs_rt = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  md_iter_step #(
    .Width (WIDTH)
  ) u_step (
    .is_div  (is_div_q),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .operand (operand_q),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  assign prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quot_fix = neg_res_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    operand_d = operand_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_mul_op || is_div_op) begin
            dbz_d = 1'b0;
            if (is_div_op && (rt_data == '0)) begin
              // Divide by zero completes on the accept edge.
              lo_d   = '1;
              hi_d   = rs_data;
              dbz_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              state_d   = StCalc;
              count_d   = '0;
              is_div_d  = is_div_op;
              acc_hi_d  = '0;
              acc_lo_d  = is_div_op ? abs_rs : abs_rt;
              operand_d = is_div_op ? abs_rt : abs_rs;
              neg_res_d = signed_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              neg_rem_d = signed_op && is_div_op && rs_data[WIDTH-1];
            end
          end else if (funct == FunctMthi) begin
            hi_d  = rs_data;
            dbz_d = 1'b0;
          end else if (funct == FunctMtlo) begin
            lo_d  = rs_data;
            dbz_d = 1'b0;
          end
        end
      end
      StCalc: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        count_d  = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (is_div_q) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      operand_q <= operand_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign mf_data     = (funct == FunctMfhi) ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal expectations plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [5:0] FMfhi  = 6'h10;
  localparam logic [5:0] FMthi  = 6'h11;
  localparam logic [5:0] FMflo  = 6'h12;
  localparam logic [5:0] FMtlo  = 6'h13;
  localparam logic [5:0] FMult  = 6'h18;
  localparam logic [5:0] FMultu = 6'h19;
  localparam logic [5:0] FDiv   = 6'h1A;
  localparam logic [5:0] FDivu  = 6'h1B;

  logic         clock;
  logic         reset;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] mf_data;

  mult_div_unit #(
    .WIDTH (W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .funct       (funct),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .mf_data     (mf_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      FMult: begin
        qv = sa * sb;
        return qv;
      end
      FMultu: return {32'b0, a} * {32'b0, b};
      FDiv: begin
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
      end
      FDivu: return {a % b, a / b};
      default: return 64'b0;
    endcase
  endfunction

  // Reference model: cycles remaining until a pending result lands.
  int           m_left;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_done, m_dbz;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
        end
      end else if (start) begin
        case (funct)
          FMult, FMultu: begin
            {p_hi, p_lo} <= ref_result(funct, rs_data, rt_data);
            m_left       <= W + 1;
            m_dbz        <= 1'b0;
          end
          FDiv, FDivu: begin
            if (rt_data == '0) begin
              m_lo   <= '1;
              m_hi   <= rs_data;
              m_dbz  <= 1'b1;
              m_done <= 1'b1;
            end else begin
              {p_hi, p_lo} <= ref_result(funct, rs_data, rt_data);
              m_left       <= W + 1;
              m_dbz        <= 1'b0;
            end
          end
          FMthi: begin
            m_hi  <= rs_data;
            m_dbz <= 1'b0;
          end
          FMtlo: begin
            m_lo  <= rs_data;
            m_dbz <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    check("busy", 64'(busy), 64'(m_left > 0));
    check("done", 64'(done), 64'(m_done));
    check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("mf_data", 64'(mf_data), 64'((funct == FMfhi) ? m_hi : m_lo));
  end

  // Drive a request for one cycle; called at posedge+2, returns at the next posedge+2.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    funct   = f;
    rs_data = a;
    rt_data = b;
    @(posedge clock);
    #2;
    start = 1'b0;
    funct = 6'h00;
  endtask

  // Issue a mult/div and check the literal result, latency and busy length.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    int nbusy;
    bit seen;
    n     = 0;
    nbusy = 0;
    seen  = 0;
    issue(f, a, b);
    while (n < 50 && !seen) begin
      @(negedge clock);
      n++;
      if (busy) nbusy++;
      if (done) seen = 1;
    end
    check({name, "_done_seen"}, 64'(seen), 64'(1));
    check({name, "_latency"}, 64'(n), 64'(W + 2));
    check({name, "_busy_cycles"}, 64'(nbusy), 64'(W + 1));
    check({name, "_hi"}, 64'(hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo), 64'(exp_lo));
    check({name, "_model_hi"}, 64'(m_hi), 64'(exp_hi));
    check({name, "_model_lo"}, 64'(m_lo), 64'(exp_lo));
    @(posedge clock);
    #2;
  endtask

  initial begin
    int ndone;
    reset   = 1'b1;
    start   = 1'b0;
    funct   = 6'h00;
    rs_data = '0;
    rt_data = '0;
    @(negedge clock);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_dbz", 64'(div_by_zero), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #2;

    run_op("mult_neg", FMult, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max", FMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg", FDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", FDivu, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("div_ovf", FDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // Divide by zero completes on the accept edge.
    issue(FDiv, 32'h1234_5678, 32'h0);
    @(negedge clock);
    check("dbz_flag", 64'(div_by_zero), 64'(1));
    check("dbz_done", 64'(done), 64'(1));
    check("dbz_busy", 64'(busy), 64'(0));
    check("dbz_lo", 64'(lo), 64'(32'hFFFF_FFFF));
    check("dbz_hi", 64'(hi), 64'(32'h1234_5678));
    @(posedge clock);
    #2;
    issue(FMultu, 32'd3, 32'd5);
    @(negedge clock);
    check("dbz_cleared", 64'(div_by_zero), 64'(0));
    repeat (W + 2) @(posedge clock);
    #2;
    check("mult_after_dbz_lo", 64'(lo), 64'(15));

    // Start while busy is ignored; reset mid-operation aborts without a done pulse.
    issue(FMult, 32'd100, 32'd200);
    repeat (3) @(posedge clock);
    #2;
    start   = 1'b1;
    funct   = FMthi;
    rs_data = 32'hAA;
    @(posedge clock);
    #2;
    start = 1'b0;
    funct = 6'h00;
    check("busy_ignore_hi", 64'(hi), 64'(0));
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    @(posedge clock);
    #2;
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'(0));
    @(posedge clock);
    #2;

    // mthi/mtlo and mfhi/mflo.
    issue(FMthi, 32'h55, 32'h0);
    issue(FMtlo, 32'h66, 32'h0);
    funct = FMfhi;
    #1;
    check("mfhi", 64'(mf_data), 64'(32'h55));
    funct = FMflo;
    #1;
    check("mflo", 64'(mf_data), 64'(32'h66));
    funct = 6'h00;
    @(posedge clock);
    #2;

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] f;
      case ($urandom_range(0, 9))
        0: f = FMult;
        1: f = FMultu;
        2: f = FDiv;
        3: f = FDivu;
        4: f = FMthi;
        5: f = FMtlo;
        6: f = FMfhi;
        7: f = FMflo;
        8: f = 6'h20;
        default: f = 6'($urandom);
      endcase
      start = ($urandom_range(0, 3) != 0);
      funct = f;
      case ($urandom_range(0, 7))
        0: rs_data = 32'h8000_0000;
        1: rs_data = 32'hFFFF_FFFF;
        2: rs_data = 32'h0;
        default: rs_data = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rt_data = 32'h0;
        1: rt_data = 32'hFFFF_FFFF;
        2: rt_data = $urandom_range(1, 9);
        default: rt_data = $urandom;
      endcase
      reset = ($urandom_range(0, 599) == 0);
      @(posedge clock);
      #2;
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
